// File: rtl/weighted_round_robin_arbiter.sv
// Weighted round-robin arbiter: each requester may keep the grant for up to its
// weight in consecutive cycles, then the grant rotates circularly to the next requester.
module weighted_round_robin_arbiter #(
   parameter int unsigned                    REQ_NUM  = 8,
   parameter int unsigned                    WEIGHT_W = 4,
   parameter logic [REQ_NUM*WEIGHT_W-1:0]    WEIGHTS  = 32'h87654321
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REQ_NUM-1:0] reqs,
   output logic [REQ_NUM-1:0] grants
);

   localparam int unsigned        PTR_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
   localparam int unsigned        CNT_W   = WEIGHT_W + 1;
   localparam logic [PTR_W-1:0]   PTR_RST = PTR_W'(REQ_NUM - 1);

   logic [REQ_NUM-1:0]  r_grants;
   logic [PTR_W-1:0]    r_ptr;
   logic [CNT_W-1:0]    r_cnt;

   logic [REQ_NUM-1:0]  w_grants_nxt;
   logic [PTR_W-1:0]    w_ptr_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [WEIGHT_W-1:0] w_wt_raw;
   logic [CNT_W-1:0]    w_quota;
   logic [PTR_W-1:0]    w_idx;
   logic                w_found;
   logic                w_hold;

   // Quota of the current holder; a zero weight still allows one cycle.
   always_comb begin
      w_wt_raw = WEIGHT_W'(WEIGHTS >> (32'(r_ptr) * WEIGHT_W));
      w_quota  = (w_wt_raw == '0) ? CNT_W'(1) : CNT_W'(w_wt_raw);
   end

   // Next-state: hold while quota remains, else search from ptr+1 ending at ptr itself.
   always_comb begin
      w_grants_nxt = '0;
      w_ptr_nxt    = r_ptr;
      w_cnt_nxt    = '0;
      w_idx        = '0;
      w_found      = 1'b0;
      w_hold       = (r_grants != '0) && reqs[r_ptr] && (r_cnt < w_quota);

      if (w_hold) begin
         w_grants_nxt = REQ_NUM'(1) << r_ptr;
         w_cnt_nxt    = r_cnt + CNT_W'(1);
      end else if (reqs != '0) begin
         for (int unsigned off = 1; off <= REQ_NUM; off++) begin
            w_idx = PTR_W'((32'(r_ptr) + off) % REQ_NUM);
            if (!w_found && reqs[w_idx]) begin
               w_found   = 1'b1;
               w_ptr_nxt = w_idx;
            end
         end
         w_grants_nxt = REQ_NUM'(1) << w_ptr_nxt;
         w_cnt_nxt    = CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grants <= '0;
         r_ptr    <= PTR_RST;
         r_cnt    <= '0;
      end else begin
         r_grants <= w_grants_nxt;
         r_ptr    <= w_ptr_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   assign grants = r_grants;

endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// Directed and randomized checks for weighted_round_robin_arbiter (default parameters).
module tb_weighted_round_robin_arbiter;

   localparam logic [31:0] WEIGHTS = 32'h87654321;

   logic       clk;
   logic       rst;
   logic [7:0] reqs;
   logic [7:0] grants;

   int n_cmp;
   int n_fail;

   // Reference model state
   logic [7:0] m_g;
   int         m_ptr;
   int         m_cnt;
   int         waitc [8];

   weighted_round_robin_arbiter #(
      .REQ_NUM  (8),
      .WEIGHT_W (4),
      .WEIGHTS  (WEIGHTS)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .reqs   (reqs),
      .grants (grants)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wt(input int i);
      logic [3:0] w;
      w = 4'(WEIGHTS >> (i * 4));
      return (w == 4'd0) ? 1 : int'(w);
   endfunction

   function automatic int starve_bound(input int i);
      int s;
      s = 0;
      for (int j = 0; j < 8; j++) if (j != i) s += wt(j);
      return s;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive reqs away from the active edge, then sample grants just after it.
   task automatic cyc(input logic [7:0] r, input logic [7:0] exp, input string tag);
      @(negedge clk);
      reqs = r;
      @(posedge clk);
      #1;
      chk(tag, grants, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      reqs = 8'hFF;
      @(posedge clk);
      #1;
      chk("reset", grants, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      reqs = 8'h00;
      m_g = 8'h00; m_ptr = 7; m_cnt = 0;
      for (int i = 0; i < 8; i++) waitc[i] = 0;
   endtask

   task automatic model_step(input logic [7:0] r);
      bit found;
      int k;
      found = 1'b0;
      if (m_g != 8'h00 && r[m_ptr] && m_cnt < wt(m_ptr)) begin
         m_cnt = m_cnt + 1;
         m_g   = 8'h01 << m_ptr;
      end else if (r != 8'h00) begin
         for (int s = 1; s <= 8; s++) begin
            k = (m_ptr + s) % 8;
            if (!found && r[k]) begin
               found = 1'b1;
               m_ptr = k;
            end
         end
         m_cnt = 1;
         m_g   = 8'h01 << m_ptr;
      end else begin
         m_cnt = 0;
         m_g   = 8'h00;
      end
   endtask

   initial begin
      logic [7:0] r;
      logic [7:0] seq3 [6];
      n_cmp = 0;
      n_fail = 0;
      rst  = 1'b1;
      reqs = 8'h00;
      seq3 = '{8'h01, 8'h02, 8'h02, 8'h01, 8'h02, 8'h02};

      // 1: reset with all requests, then first grant goes to req0
      do_reset();
      cyc(8'hFF, 8'h01, "t1_first");
      cyc(8'hFF, 8'h02, "t1_second");
      cyc(8'hFF, 8'h02, "t1_third");
      cyc(8'hFF, 8'h04, "t1_fourth");

      // 2: single requester, no bubbles
      do_reset();
      for (int i = 0; i < 5; i++) cyc(8'h01, 8'h01, "t2_single");

      // 3: two weighted requesters
      do_reset();
      for (int i = 0; i < 12; i++) cyc(8'h03, seq3[i % 6], "t3_two");

      // 4: wrap 7 -> 0 with max weight
      do_reset();
      for (int i = 0; i < 18; i++)
         cyc(8'h81, ((i % 9) == 0) ? 8'h01 : 8'h80, "t4_wrap");
      // mid-operation reset clears grant regardless of reqs
      do_reset();
      cyc(8'h81, 8'h01, "t4_after_rst");

      // 5: holder drop forfeits quota; re-acquire starts fresh
      do_reset();
      cyc(8'h06, 8'h02, "t5_a");
      cyc(8'h06, 8'h02, "t5_b");
      cyc(8'h06, 8'h04, "t5_c");
      cyc(8'h02, 8'h02, "t5_drop");
      cyc(8'h02, 8'h02, "t5_fresh2");
      cyc(8'h06, 8'h04, "t5_rotate");

      // 6: idle then resume after last holder
      do_reset();
      cyc(8'h0F, 8'h01, "t6_a");
      cyc(8'h0F, 8'h02, "t6_b");
      cyc(8'h00, 8'h00, "t6_idle1");
      cyc(8'h00, 8'h00, "t6_idle2");
      cyc(8'h0F, 8'h04, "t6_resume");

      // 7: random traffic against the reference model and invariants
      do_reset();
      for (int c = 0; c < 500; c++) begin
         r = 8'($urandom) | 8'($urandom);
         if ((c % 37) == 5) r = 8'h00;
         model_step(r);
         cyc(r, m_g, "t7_model");
         chk("t7_onehot", 8'($onehot0(grants)), 8'h01);
         chk("t7_subset", grants & ~r, 8'h00);
         for (int i = 0; i < 8; i++) begin
            if (r[i] && !grants[i]) waitc[i]++;
            else waitc[i] = 0;
            n_cmp++;
            assert (waitc[i] <= starve_bound(i)) else begin
               n_fail++;
               $error("FAIL t7_starve req%0d: observed wait %0d expected <= %0d",
                      i, waitc[i], starve_bound(i));
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
